// File: rtl/bus_uart_tx_if.sv
// CPU-side register bus for the memory-mapped UART transmitter.
// The master drives select, address, write enable and write data; the slave returns registered read data.
interface bus_uart_tx_if;
  logic       cs;
  logic [1:0] addr;
  logic       we;
  logic [7:0] di;
  logic [7:0] dout;

  modport master (output cs, addr, we, di, input dout);
  modport slave  (input cs, addr, we, di, output dout);
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the cpu6502 bus.
// Bytes are pushed into a small TX FIFO and serialised on tx; irq is raised once the FIFO is drained.
module bus_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  bus_uart_tx_if.slave bus,
  output logic        irq,
  output logic        tx
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [PtrW:0]    count_q, count_d;

  logic             ovf_q, irq_en_q, irq_q;
  logic [7:0]       dout_q, rdata, status;
  logic             empty, full, busy, push, pop, baud_end;
  logic             wr_data, wr_status, wr_ctrl;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign busy      = (state_q != StIdle);
  assign baud_end  = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign wr_data   = bus.cs & bus.we & (bus.addr == 2'd0);
  assign wr_status = bus.cs & bus.we & (bus.addr == 2'd1);
  assign wr_ctrl   = bus.cs & bus.we & (bus.addr == 2'd2);
  // Full is the registered value, so a push is refused even if a pop happens this cycle.
  assign push      = wr_data & ~full;
  assign status    = {ovf_q, 4'b0000, busy, empty, full};

  always_comb begin
    case (bus.addr)
      2'd1:    rdata = status;
      2'd2:    rdata = {7'b0000000, irq_en_q};
      default: rdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      StIdle:  pop = ~empty;
      StStart: begin
        if (baud_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      default: begin
        // End of stop bit chains straight into the next start bit when data is waiting.
        if (baud_end) begin
          pop     = ~empty;
          state_d = StIdle;
        end
      end
    endcase
    if (pop) begin
      state_d = StStart;
      tx_d    = 1'b0;
      shift_d = mem_q[rd_q];
    end
    baud_d = (state_q == StIdle || baud_end) ? '0 : baud_q + BaudW'(1);
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW+1)'(1);
      2'b01:   count_d = count_q - (PtrW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.di;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
      if (wr_status)          ovf_q <= 1'b0;
      else if (wr_data && full) ovf_q <= 1'b1;
      if (wr_ctrl) irq_en_q <= bus.di[0];
      irq_q <= irq_en_q & empty & ~busy;
      if (bus.cs && !bus.we) dout_q <= rdata;
    end
  end

  assign bus.dout = dout_q;
  assign irq      = irq_q;
  assign tx       = tx_q;

endmodule
